cic_comp_fir: RTL and testbench

CIC_COMP_FIR -- requirements
Module: cic_comp_fir

---
 rtl/cic_comp_pkg.sv | 28 ++
 rtl/cic_comp_ring.sv | 55 +++++
 rtl/cic_comp_fir.sv | 153 +++++++++++++++
 tb/tb_cic_comp_fir.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_comp_pkg.sv
// Shared coefficients, FSM state type and width helpers for the CIC compensation FIR.
package cic_comp_pkg;

  localparam int COMP_W    = 10;
  localparam int COMP_CW   = 12;
  localparam int COMP_NTAP = 15;

  // Half of a symmetric inverse-sinc^2 style response; centre tap last, DC gain 2048.
  localparam logic signed [COMP_CW-1:0] COMP_COEF [0:(COMP_NTAP+1)/2-1] = '{
    12'sd3, -12'sd8, 12'sd14, -12'sd26, 12'sd48, -12'sd110, 12'sd300, 12'sd1606
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_ROUND,
    ST_OUT
  } state_t;

  function automatic int accWidth(input int w, input int cw, input int ntap);
    return w + 1 + cw + $clog2((ntap + 1) / 2);
  endfunction

  function automatic int preAddWidth(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/cic_comp_ring.sv
// NTAP-entry circular sample buffer: one write port, two combinational read ports
// addressed relative to the write pointer (newest-k and oldest+k).
module cic_comp_ring
  import cic_comp_pkg::*;
#(
  parameter int W    = 10,
  parameter int NTAP = 15,
  parameter int KW   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic signed [W-1:0] i_wdata,
  input  logic [KW-1:0]       i_k,
  output logic signed [W-1:0] o_rd_a,
  output logic signed [W-1:0] o_rd_b
);

  localparam int PW  = $clog2(NTAP);
  localparam int PW1 = PW + 1;
  localparam logic [PW:0]   L_N    = PW1'(NTAP);
  localparam logic [PW:0]   L_NM1  = PW1'(NTAP - 1);
  localparam logic [PW-1:0] L_LAST = PW'(NTAP - 1);

  logic signed [W-1:0] r_mem [NTAP];
  logic [PW-1:0]       r_wptr;
  logic [PW:0]         w_sum_a;
  logic [PW:0]         w_sum_b;
  logic [PW-1:0]       w_addr_a;
  logic [PW-1:0]       w_addr_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      for (int i = 0; i < NTAP; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[r_wptr] <= i_wdata;
      r_wptr        <= (r_wptr == L_LAST) ? '0 : r_wptr + PW'(1);
    end
  end

  // Both sums stay below 2*NTAP, so a single conditional subtract is a full modulo.
  always_comb begin
    w_sum_a  = {1'b0, r_wptr} + L_NM1 - PW1'(i_k);
    w_sum_b  = {1'b0, r_wptr} + PW1'(i_k);
    w_addr_a = (w_sum_a >= L_N) ? PW'(w_sum_a - L_N) : w_sum_a[PW-1:0];
    w_addr_b = (w_sum_b >= L_N) ? PW'(w_sum_b - L_N) : w_sum_b[PW-1:0];
  end

  assign o_rd_a = r_mem[w_addr_a];
  assign o_rd_b = r_mem[w_addr_b];

endmodule

// File: rtl/cic_comp_fir.sv
// Symmetric CIC droop-compensation FIR, one folded MAC per cycle.
// Define CIC_COMP_SAT_EN to saturate the output; otherwise the result wraps to W bits.
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int W    = COMP_W,
  parameter int CW   = COMP_CW,
  parameter int NTAP = COMP_NTAP,
  parameter logic signed [CW-1:0] COEF [0:(NTAP+1)/2-1] = COMP_COEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                eni,
  input  logic signed [W-1:0] in,
  output logic signed [W-1:0] out,
  output logic                eno,
  output logic                drop
);

  localparam int NH  = (NTAP + 1) / 2;
  localparam int KW  = $clog2(NH);
  localparam int AW  = accWidth(W, CW, NTAP);
  localparam int PAW = preAddWidth(W);
  localparam int PRW = PAW + CW;
  localparam logic [KW-1:0]        K_LAST = KW'(NH - 1);
  localparam logic signed [AW-1:0] L_RND  = AW'(2 ** (CW - 2));

  state_t               r_state;
  state_t               w_next;
  logic [KW-1:0]        r_k;
  logic signed [AW-1:0] r_acc;
  logic signed [W-1:0]  r_out;
  logic                 r_eno;
  logic                 w_accept;
  logic                 w_drop;
  logic                 w_last;
  logic signed [W-1:0]  w_rd_a;
  logic signed [W-1:0]  w_rd_b;
  logic signed [CW-1:0] w_coef;
  logic signed [PAW-1:0] w_pre;
  logic signed [PRW-1:0] w_prod;
  logic signed [W-1:0]  w_narrow;

  cic_comp_ring #(
    .W    (W),
    .NTAP (NTAP),
    .KW   (KW)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_accept),
    .i_wdata (in),
    .i_k     (r_k),
    .o_rd_a  (w_rd_a),
    .o_rd_b  (w_rd_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Reset outranks a strobe: nothing is accepted or flagged while rst is high.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_drop   = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (eni) begin
            w_accept = 1'b1;
            w_next   = ST_MAC;
          end
        end
        ST_MAC: begin
          w_drop = eni;
          if (w_last) w_next = ST_ROUND;
        end
        ST_ROUND: begin
          w_drop = eni;
          w_next = ST_OUT;
        end
        ST_OUT: begin
          w_drop = eni;
          w_next = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // The centre tap has no mirror partner, so it skips the pre-add.
  assign w_last = (r_k == K_LAST);
  assign w_coef = COEF[r_k];
  assign w_pre  = w_last ? {w_rd_a[W-1], w_rd_a}
                         : {w_rd_a[W-1], w_rd_a} + {w_rd_b[W-1], w_rd_b};
  assign w_prod = PRW'(w_pre) * PRW'(w_coef);

`ifdef CIC_COMP_SAT_EN
  localparam logic signed [AW-1:0] L_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] L_MIN = ~L_MAX;

  always_comb begin
    if (r_acc > L_MAX) begin
      w_narrow = L_MAX[W-1:0];
    end else if (r_acc < L_MIN) begin
      w_narrow = L_MIN[W-1:0];
    end else begin
      w_narrow = r_acc[W-1:0];
    end
  end
`else
  assign w_narrow = r_acc[W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k   <= '0;
      r_acc <= '0;
      r_out <= '0;
      r_eno <= 1'b0;
    end else begin
      r_eno <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_acc <= '0;
            r_k   <= '0;
          end
        end
        ST_MAC: begin
          r_acc <= r_acc + AW'(w_prod);
          r_k   <= r_k + KW'(1);
        end
        ST_ROUND: r_acc <= (r_acc + L_RND) >>> (CW - 1);
        ST_OUT: begin
          r_out <= w_narrow;
          r_eno <= 1'b1;
        end
        default: r_eno <= 1'b0;
      endcase
    end
  end

  assign out  = r_out;
  assign eno  = r_eno;
  assign drop = w_drop;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Bench for cic_comp_fir: vector tables, corner sequences and a random run
// checked against a direct-form convolution model of the filter.
module tb_cic_comp_fir;
  import cic_comp_pkg::*;

  localparam int W    = 10;
  localparam int NTAP = 15;
  localparam int NH   = 8;
  localparam int GAP  = 16;
  localparam int LAT  = 11;
  localparam logic signed [11:0] SAT_COEF [0:7] = '{default: 12'sd2047};
  localparam logic signed [W-1:0] X_OVR1 = 10'sd200;
  localparam logic signed [W-1:0] X_OVR2 = -10'sd300;
`ifdef CIC_COMP_SAT_EN
  localparam logic signed [W-1:0] SAT_EXP = 10'sd511;
`else
  localparam logic signed [W-1:0] SAT_EXP = 10'sd475;
`endif

  logic clk = 1'b0;
  logic rst, eni, eno, drop;
  logic satEni, satEno, satDrop;
  logic signed [W-1:0] inSample, out, satIn, satOut;

  int nChecks = 0;
  int nFails  = 0;
  int hFull [NTAP];
  logic signed [W-1:0] hist [$];

  typedef struct {
    logic signed [W-1:0] x;
    logic signed [W-1:0] expOut;
  } vec_t;

  vec_t impTab [16];
  vec_t dcTab  [20];

  always #5 clk = ~clk;

  cic_comp_fir dut (
    .clk  (clk),
    .rst  (rst),
    .eni  (eni),
    .in   (inSample),
    .out  (out),
    .eno  (eno),
    .drop (drop)
  );

  cic_comp_fir #(.COEF(SAT_COEF)) dutSat (
    .clk  (clk),
    .rst  (rst),
    .eni  (satEni),
    .in   (satIn),
    .out  (satOut),
    .eno  (satEno),
    .drop (satDrop)
  );

  function automatic longint roundQ(input longint s);
    return (s + 64'sd1024) >>> 11;
  endfunction

  function automatic logic signed [W-1:0] narrowVal(input longint v);
`ifdef CIC_COMP_SAT_EN
    if (v > 511) return {1'b0, {(W-1){1'b1}}};
    if (v < -512) return {1'b1, {(W-1){1'b0}}};
`endif
    return W'(v);
  endfunction

  // y[n] = sum_j h[j]*x[n-j] over the accepted-sample history (missing samples are zero).
  function automatic logic signed [W-1:0] modelOut();
    longint s = 0;
    for (int j = 0; j < NTAP; j++) begin
      if (hist.size() > j) s += longint'(hFull[j]) * longint'(hist[hist.size()-1-j]);
    end
    return narrowVal(roundQ(s));
  endfunction

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic signed [W-1:0] x, input int gap,
                               output logic signed [W-1:0] gotOut, output int lat,
                               output int enoCount, output int dropCount);
    gotOut = 'x;
    lat = -1;
    enoCount = 0;
    dropCount = 0;
    eni = 1'b1;
    inSample = x;
    for (int c = 0; c < gap; c++) begin
      @(negedge clk);
      if (drop) dropCount++;
      if (eno) begin
        enoCount++;
        if (lat < 0) begin
          lat = c;
          gotOut = out;
        end
      end
      @(posedge clk); #1;
      eni = 1'b0;
      inSample = '0;
    end
  endtask

  task automatic runVector(input string tag, input logic signed [W-1:0] x,
                           input logic signed [W-1:0] expOut, input int gap);
    logic signed [W-1:0] got;
    int lat, enos, drops;
    applyStimulus(x, gap, got, lat, enos, drops);
    checkOutput({tag, " out"}, got, expOut);
    checkOutput({tag, " latency"}, lat, LAT);
    checkOutput({tag, " eno count"}, enos, 1);
    checkOutput({tag, " drop count"}, drops, 0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    eni = 1'b0;
    satEni = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    hist.delete();
  endtask

  task automatic runImpulseTable(input string tag);
    for (int j = 0; j < 16; j++) begin
      hist.push_back(impTab[j].x);
      runVector($sformatf("%s[%0d]", tag, j), impTab[j].x, impTab[j].expOut, GAP);
    end
  endtask

  initial begin
    logic signed [W-1:0] got, rv;
    int lat, enos, drops, dropCyc;
    longint cum;

    for (int j = 0; j < NTAP; j++) hFull[j] = COMP_COEF[(j < NH) ? j : NTAP - 1 - j];
    cum = 0;
    for (int j = 0; j < 16; j++) begin
      impTab[j].x = (j == 0) ? 10'sd100 : 10'sd0;
      impTab[j].expOut = (j < NTAP) ? narrowVal(roundQ(longint'(100) * hFull[j])) : 10'sd0;
    end
    for (int j = 0; j < 20; j++) begin
      if (j < NTAP) cum += hFull[j];
      dcTab[j].x = 10'sd256;
      dcTab[j].expOut = (j >= NTAP - 1) ? 10'sd256 : narrowVal(roundQ(longint'(256) * cum));
    end

    rst = 1'b1; eni = 1'b0; inSample = '0; satEni = 1'b0; satIn = '0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    eni = 1'b1;
    inSample = 10'sd77;
    @(negedge clk);
    checkOutput("reset out", out, 0);
    checkOutput("reset eno", eno, 0);
    checkOutput("reset drop with eni", drop, 0);
    checkOutput("reset sat out", satOut, 0);
    @(posedge clk); #1;
    eni = 1'b0;
    rst = 1'b0;
    inSample = '0;
    hist.delete();

    runImpulseTable("impulse");

    doReset();
    for (int j = 0; j < 20; j++) begin
      hist.push_back(dcTab[j].x);
      runVector($sformatf("dc[%0d]", j), dcTab[j].x, dcTab[j].expOut, GAP);
    end

    // Second strobe lands mid-MAC and must be discarded.
    doReset();
    eni = 1'b1; inSample = X_OVR1;
    drops = 0; dropCyc = -1; enos = 0; lat = -1; got = 'x;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (drop) begin
        drops++;
        dropCyc = c;
      end
      if (eno) begin
        enos++;
        if (lat < 0) begin
          lat = c;
          got = out;
        end
      end
      @(posedge clk); #1;
      eni = (c == 3);
      inSample = (c == 3) ? X_OVR2 : '0;
    end
    hist.push_back(X_OVR1);
    checkOutput("overrun drop count", drops, 1);
    checkOutput("overrun drop cycle", dropCyc, 4);
    checkOutput("overrun eno count", enos, 1);
    checkOutput("overrun latency", lat, LAT);
    checkOutput("overrun out", got, modelOut());
    hist.push_back(10'sd50);
    runVector("overrun follow", 10'sd50, modelOut(), GAP);

    // Reset in cycle 5 after a strobe aborts that computation.
    doReset();
    eni = 1'b1; inSample = 10'sd100; enos = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (eno) enos++;
      @(posedge clk); #1;
      eni = 1'b0;
      inSample = '0;
      rst = (c == 4);
    end
    hist.delete();
    checkOutput("abort eno count", enos, 0);
    checkOutput("abort out", out, 0);
    runImpulseTable("post-abort impulse");

    for (int i = 0; i < 40; i++) begin
      rv = W'($urandom_range(0, 1023));
      hist.push_back(rv);
      runVector($sformatf("rand[%0d]", i), rv, modelOut(), int'($urandom_range(12, 18)));
    end

    doReset();
    for (int i = 0; i < 35; i++) begin
      rv = W'(i);
      hist.push_back(rv);
      runVector($sformatf("ramp[%0d]", i), rv, modelOut(), GAP);
    end

    for (int s = 0; s < 16; s++) begin
      satEni = 1'b1;
      satIn = 10'sd100;
      got = 'x;
      lat = -1;
      for (int c = 0; c < GAP; c++) begin
        @(negedge clk);
        if (satEno && lat < 0) begin
          lat = c;
          got = satOut;
        end
        @(posedge clk); #1;
        satEni = 1'b0;
      end
      if (s >= NTAP - 1) checkOutput($sformatf("narrow[%0d]", s), got, SAT_EXP);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
